strobe_source: RTL and testbench
================================

Name: strobe_source

Overview:
- Drives the 4-bit data / 2-bit strobe pin interface that the synchronized-capture logic samples; it is the transmit end of the same link.
- Buffers words written by a local producer, such as a UART command decoder or test-pattern sequencer, in a small FIFO.
- Replays each word on data_out, then issues a strobe pulse with programmable setup, pulse and hold widths.
- Timing is sized for a receiver that passes the pins through a 2-flop synchronizer.

Parameters:
- DATA_W, 4: width of data_out and wr_data.
- STROBE_W, 2: width of strobe_out and wr_strobe.
- DEPTH, 8: FIFO entries; power of two, ≥2.
- SETUP_CYC, 3: cycles data_out is stable before strobe asserts; ≥1.
- PULSE_CYC, 3: cycles strobe_out is held high; ≥1.
- HOLD_CYC, 3: cycles data_out is held after strobe deasserts; ≥1.

Ports:
- clk  in  1  single system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  when low, no new FIFO entry is started; a word in flight completes.
- wr_valid  in  1  producer has a word.
- wr_ready  out  1  FIFO not full.
- wr_data  in  DATA_W  word to drive.
- wr_strobe  in  STROBE_W  strobe lines to pulse for this word; 0 means a data-only update.
- data_out  out  DATA_W  registered pin data.
- strobe_out  out  STROBE_W  registered pin strobes.
- busy  out  1  FSM not in IDLE.
- fifo_count  out  clog2(DEPTH)+1  entries currently stored.

Behaviour:
- Reset (async assert, sync release) sets:
  - data_out=0, strobe_out=0, busy=0, fifo_count=0, wr_ready=1.
  - FSM=IDLE; FIFO pointers=0.
- Write handshake:
  - A word is accepted on an edge where wr_valid && wr_ready.
  - wr_ready = (fifo_count != DEPTH), derived from registered state.
  - When full, wr_valid is ignored; no overwrite, no error flag.
- FIFO:
  - Circular buffer with wrap-around pointers.
  - Simultaneous accept and pop on one edge leaves fifo_count unchanged.
  - A word written into an empty FIFO is visible to a pop on the following edge; there is no same-edge bypass.
- FSM states: IDLE, SETUP, PULSE, HOLD. A single phase counter is reloaded on each transition. "Pop edge" P is the edge that pops an entry.
- IDLE:
  - If enable && fifo_count>0, the edge pops the head entry.
  - On that edge, data_out <= wr_data of the entry, the entry's strobe mask is latched internally, and the FSM moves to SETUP.
- SETUP:
  - Lasts SETUP_CYC cycles with strobe_out=0.
  - Its last edge sets strobe_out <= latched mask, moves to PULSE.
  - So strobe_out rises at P+SETUP_CYC.
- PULSE:
  - Lasts PULSE_CYC cycles.
  - Its last edge sets strobe_out <= 0, moves to HOLD.
  - With a mask of 0, the phase still runs with strobe_out=0, so the word period is constant.
- HOLD:
  - Lasts HOLD_CYC cycles; data_out is unchanged.
  - On its last edge:
    - if enable && fifo_count>0, pop the next entry directly and go to SETUP;
    - else go to IDLE.
- Back-to-back period: SETUP_CYC+PULSE_CYC+HOLD_CYC cycles per word (default 9).
- data_out retains the last word while IDLE.
- strobe_out changes only on SETUP→PULSE and PULSE→HOLD edges, never in the same cycle as data_out.
- busy=1 in SETUP, PULSE and HOLD.
- enable deasserted mid-transfer: the current word finishes its full SETUP/PULSE/HOLD, then the FSM idles.
- Reset mid-transfer:
  - strobe_out drops to 0 immediately (asynchronously);
  - FIFO contents are discarded (count=0);
  - no partial pulse resumes after reset release.
- Arithmetic: phase counter is clog2(max(SETUP_CYC,PULSE_CYC,HOLD_CYC))+1 bits; pointers wrap modulo DEPTH; fifo_count never exceeds DEPTH or underflows.

Test Plan:
- Single word, default params:
  - stimulus: write data=0xA, strobe=2'b01 at edge E, enable=1;
  - response: pop at E+1, data_out=0xA from E+1, strobe_out=01 for edges E+4..E+6 (3 cycles), busy falls at E+10.
- Back-to-back:
  - stimulus: write 0x1/01, 0x2/10, 0x3/11 on consecutive edges;
  - response: data_out changes every 9 cycles exactly, strobe pulses 01, 10, 11 each 3 cycles wide, no IDLE gap between words.
- Full FIFO:
  - stimulus: enable=0, 10 writes of 0x0..0x9;
  - response: wr_ready=0 after the 8th, fifo_count=8; after enable=1, outputs are 0x0..0x7 only.
- Mask zero:
  - stimulus: write 0x5/00;
  - response: data_out=0x5, strobe_out stays 0, busy high for 9 cycles.
- enable drop:
  - stimulus: 3 words queued, enable=0 during the first word's PULSE;
  - response: first word completes HOLD, FSM IDLE, fifo_count=2, no further data_out change until enable=1.
- Async reset:
  - stimulus: assert rst_n=0 mid-PULSE with strobe_out=11;
  - response: strobe_out=0 and data_out=0 without a clock edge, fifo_count=0; after release no strobe activity.

Source files
------------

// File: rtl/strobe_source.sv
// Transmit end of the 4-bit data / 2-bit strobe pin link: a small FIFO feeds
// a SETUP/PULSE/HOLD sequencer that replays each word with a timed strobe pulse.
module strobe_source #(
   parameter int DATA_W    = 4,
   parameter int STROBE_W  = 2,
   parameter int DEPTH     = 8,
   parameter int SETUP_CYC = 3,
   parameter int PULSE_CYC = 3,
   parameter int HOLD_CYC  = 3
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       enable,
   input  logic                       wr_valid,
   output logic                       wr_ready,
   input  logic [DATA_W-1:0]          wr_data,
   input  logic [STROBE_W-1:0]        wr_strobe,
   output logic [DATA_W-1:0]          data_out,
   output logic [STROBE_W-1:0]        strobe_out,
   output logic                       busy,
   output logic [$clog2(DEPTH):0]     fifo_count
);

   localparam int AW   = $clog2(DEPTH);
   localparam int MAX1 = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
   localparam int MAXC = (MAX1 > HOLD_CYC) ? MAX1 : HOLD_CYC;
   localparam int CW   = $clog2(MAXC) + 1;
   localparam int EW   = DATA_W + STROBE_W;

   typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

   state_t              state, state_nxt;
   logic [CW-1:0]       cnt, cnt_nxt;
   logic [STROBE_W-1:0] mask, mask_nxt;
   logic [DATA_W-1:0]   data_nxt;
   logic [STROBE_W-1:0] strobe_nxt;
   logic                pop, push, can_pop;

   logic [EW-1:0]       mem [DEPTH];
   logic [AW-1:0]       wr_ptr, rd_ptr;
   logic [EW-1:0]       head;

   assign wr_ready = (fifo_count != (AW+1)'(DEPTH));
   assign push     = wr_valid && wr_ready;
   assign head     = mem[rd_ptr];
   assign can_pop  = enable && (fifo_count != '0);
   assign busy     = (state != IDLE);

   // Storage has no reset; the pointers and count alone define what is valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {wr_data, wr_strobe};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
            2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         mask       <= '0;
         data_out   <= '0;
         strobe_out <= '0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         mask       <= mask_nxt;
         data_out   <= data_nxt;
         strobe_out <= strobe_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      mask_nxt   = mask;
      data_nxt   = data_out;
      strobe_nxt = strobe_out;
      pop        = 1'b0;
      case (state)
         IDLE: begin
            if (can_pop) begin
               pop       = 1'b1;
               data_nxt  = head[EW-1:STROBE_W];
               mask_nxt  = head[STROBE_W-1:0];
               state_nxt = SETUP;
               cnt_nxt   = CW'(SETUP_CYC - 1);
            end
         end
         SETUP: begin
            if (cnt == '0) begin
               strobe_nxt = mask;
               state_nxt  = PULSE;
               cnt_nxt    = CW'(PULSE_CYC - 1);
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         PULSE: begin
            if (cnt == '0) begin
               strobe_nxt = '0;
               state_nxt  = HOLD;
               cnt_nxt    = CW'(HOLD_CYC - 1);
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         HOLD: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - CW'(1);
            end else if (can_pop) begin
               // Chain straight into the next word so back-to-back words have no idle gap.
               pop       = 1'b1;
               data_nxt  = head[EW-1:STROBE_W];
               mask_nxt  = head[STROBE_W-1:0];
               state_nxt = SETUP;
               cnt_nxt   = CW'(SETUP_CYC - 1);
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_strobe_source.sv
// Directed bench for strobe_source: single word, back-to-back, full FIFO,
// zero mask, enable drop and asynchronous reset mid-pulse.
module tb_strobe_source;

   logic       clk;
   logic       rst_n;
   logic       enable;
   logic       wr_valid;
   logic       wr_ready;
   logic [3:0] wr_data;
   logic [1:0] wr_strobe;
   logic [3:0] data_out;
   logic [1:0] strobe_out;
   logic       busy;
   logic [3:0] fifo_count;

   int errors = 0;
   int checks = 0;

   strobe_source dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_data    (wr_data),
      .wr_strobe  (wr_strobe),
      .data_out   (data_out),
      .strobe_out (strobe_out),
      .busy       (busy),
      .fifo_count (fifo_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   logic [1:0] masks [3];
   int k, w, o;

   initial begin
      rst_n = 1'b0; enable = 1'b0; wr_valid = 1'b0; wr_data = '0; wr_strobe = '0;
      step(3);
      rst_n = 1'b1;
      step(1);
      chk("rst_data", data_out, 0);
      chk("rst_strobe", strobe_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_ready", wr_ready, 1);

      // Single word: written at edge E, popped at E+1.
      enable = 1'b1; wr_valid = 1'b1; wr_data = 4'hA; wr_strobe = 2'b01;
      step(1);
      wr_valid = 1'b0;
      chk("t1_count_E", fifo_count, 1);
      chk("t1_busy_E", busy, 0);
      step(1);
      chk("t1_data_E1", data_out, 4'hA);
      chk("t1_busy_E1", busy, 1);
      chk("t1_count_E1", fifo_count, 0);
      step(2);
      chk("t1_strobe_E3", strobe_out, 0);
      step(1);
      chk("t1_strobe_E4", strobe_out, 2'b01);
      step(2);
      chk("t1_strobe_E6", strobe_out, 2'b01);
      step(1);
      chk("t1_strobe_E7", strobe_out, 0);
      chk("t1_data_E7", data_out, 4'hA);
      step(2);
      chk("t1_busy_E9", busy, 1);
      step(1);
      chk("t1_busy_E10", busy, 0);
      chk("t1_data_E10", data_out, 4'hA);

      // Back-to-back: three words on consecutive edges E..E+2.
      masks[0] = 2'b01; masks[1] = 2'b10; masks[2] = 2'b11;
      wr_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wr_data = 4'(i + 1); wr_strobe = masks[i];
         step(1);
      end
      wr_valid = 1'b0;
      chk("t2_count", fifo_count, 2);
      chk("t2_data_first", data_out, 1);
      for (int t = 3; t <= 27; t++) begin
         step(1);
         k = t - 1; w = k / 9; o = k % 9;
         chk("t2_data", data_out, w + 1);
         chk("t2_strobe", strobe_out, (o >= 3 && o <= 5) ? masks[w] : 2'b00);
         chk("t2_busy", busy, 1);
      end
      step(1);
      chk("t2_idle_busy", busy, 0);
      chk("t2_idle_data", data_out, 3);

      // Full FIFO with enable low: 10 writes, only 8 stored.
      enable = 1'b0; wr_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         wr_data = 4'(i); wr_strobe = 2'b01;
         step(1);
         chk("t3_count", fifo_count, (i < 8) ? i + 1 : 8);
         chk("t3_ready", wr_ready, (i < 7) ? 1 : 0);
      end
      wr_valid = 1'b0;
      chk("t3_idle", busy, 0);
      enable = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step(1);
         chk("t3_out", data_out, i);
         if (i < 7) step(8);
      end
      step(9);
      chk("t3_end_busy", busy, 0);
      chk("t3_end_data", data_out, 7);
      chk("t3_end_count", fifo_count, 0);

      // Mask zero: word period still 9 cycles, no strobe.
      wr_valid = 1'b1; wr_data = 4'h5; wr_strobe = 2'b00;
      step(1);
      wr_valid = 1'b0;
      step(1);
      chk("t4_data", data_out, 4'h5);
      for (int i = 0; i < 9; i++) begin
         chk("t4_strobe", strobe_out, 0);
         chk("t4_busy", busy, 1);
         step(1);
      end
      chk("t4_busy_end", busy, 0);

      // Enable drop during the first word's pulse.
      enable = 1'b0; wr_valid = 1'b1;
      wr_data = 4'hB; wr_strobe = 2'b01; step(1);
      wr_data = 4'hC; wr_strobe = 2'b10; step(1);
      wr_data = 4'hD; wr_strobe = 2'b11; step(1);
      wr_valid = 1'b0;
      chk("t5_count3", fifo_count, 3);
      enable = 1'b1;
      step(1);
      chk("t5_data_b", data_out, 4'hB);
      chk("t5_count2", fifo_count, 2);
      step(4);
      chk("t5_pulse", strobe_out, 2'b01);
      enable = 1'b0;
      step(5);
      chk("t5_idle", busy, 0);
      chk("t5_hold_data", data_out, 4'hB);
      chk("t5_hold_count", fifo_count, 2);
      step(5);
      chk("t5_still_idle", busy, 0);
      chk("t5_still_data", data_out, 4'hB);
      enable = 1'b1;
      step(1);
      chk("t5_data_c", data_out, 4'hC);
      step(9);
      chk("t5_data_d", data_out, 4'hD);
      step(4);
      chk("t6_pulse11", strobe_out, 2'b11);

      // Asynchronous reset mid-pulse, checked before the next clock edge.
      #2 rst_n = 1'b0;
      #1;
      chk("t6_strobe", strobe_out, 0);
      chk("t6_data", data_out, 0);
      chk("t6_count", fifo_count, 0);
      chk("t6_busy", busy, 0);
      chk("t6_ready", wr_ready, 1);
      step(2);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step(1);
         chk("t6_post_strobe", strobe_out, 0);
         chk("t6_post_busy", busy, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
